shift_sequencer: RTL and testbench



---
 rtl/alu_pkg.sv | 11 +
 rtl/shift_sequencer_if.sv | 17 +
 rtl/shift_step.sv | 19 +
 rtl/shift_sequencer.sv | 51 +++++
 tb/tb_shift_sequencer.sv | 115 +++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU constants for shift op encodings, sequencer FSM states and default width
package alu_pkg;
    localparam int DEF_WIDTH = 8;
    localparam logic [1:0] OP_LSR = 2'b00;
    localparam logic [1:0] OP_ASR = 2'b01;
    localparam logic [1:0] OP_LSL = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;
    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_SHIFT = 2'b01;
    localparam logic [1:0] S_DONE  = 2'b10;
endpackage

// File: rtl/shift_sequencer_if.sv
// shift_sequencer_if: request and result bundle between the ALU execute path and the shift sequencer
interface shift_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH) + 1
);
    logic             start;
    logic [1:0]       op;
    logic [AMT_W-1:0] amount;
    logic [WIDTH-1:0] data_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;
    modport master (output start, op, amount, data_in, input busy, done, result, carry, zero);
    modport slave  (input start, op, amount, data_in, output busy, done, result, carry, zero);
endinterface

// File: rtl/shift_step.sv
// shift_step: combinational single-bit shift/rotate step with the bit shifted out
module shift_step
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] din,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] dout,
    output logic             out_bit
);
    always_comb begin
        dout    = op == OP_LSL ? {din[WIDTH-2:0], 1'b0}
                : op == OP_ASR ? {din[WIDTH-1], din[WIDTH-1:1]}
                : op == OP_ROR ? {din[0], din[WIDTH-1:1]}
                :                {1'b0, din[WIDTH-1:1]};
        out_bit = op == OP_LSL ? din[WIDTH-1] : din[0];
    end
endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle shift/rotate unit applying one single-bit step per clock
module shift_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int AMT_W = $clog2(WIDTH) + 1
) (
    input logic              clk,
    input logic              rst,
    shift_sequencer_if.slave bus
);
    logic [1:0]       state;
    logic [1:0]       opl;
    logic [AMT_W-1:0] count;
    logic [AMT_W-1:0] sat;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] nxt;
    logic             c;
    logic             nbit;
    shift_step #(.WIDTH(WIDTH)) u_step (.din(r), .op(opl), .dout(nxt), .out_bit(nbit));
    assign sat = bus.amount > AMT_W'(WIDTH) ? AMT_W'(WIDTH) : bus.amount;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            r     <= '0;
            c     <= 1'b0;
            count <= '0;
            opl   <= OP_LSR;
        end else if (state == S_IDLE) begin
            if (bus.start) begin
                r     <= bus.data_in;
                c     <= 1'b0;
                count <= sat;
                opl   <= bus.op;
                state <= sat == '0 ? S_DONE : S_SHIFT;
            end
        end else if (state == S_SHIFT) begin
            r     <= nxt;
            c     <= nbit;
            count <= count - AMT_W'(1);
            state <= count == AMT_W'(1) ? S_DONE : S_SHIFT;
        end else begin
            state <= S_IDLE;
        end
    end
    assign bus.busy   = state != S_IDLE;
    assign bus.done   = state == S_DONE;
    assign bus.result = r;
    assign bus.carry  = c;
    assign bus.zero   = r == '0;
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: randomized and directed checks of shift_sequencer against an arithmetic model
module tb_shift_sequencer;
    import alu_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    shift_sequencer_if #(.WIDTH(8), .AMT_W(4)) bus ();
    shift_sequencer #(.WIDTH(8), .AMT_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [1:0] op, input int amt, input int d,
                                  output int res, output int cy);
        int n = amt > 8 ? 8 : amt;
        int s = d >= 128 ? d - 256 : d;
        res = d;
        cy  = 0;
        if (n == 0) return;
        case (op)
            OP_LSR: begin res = d >> n; cy = (d >> (n - 1)) & 1; end
            OP_ASR: begin res = (s >>> n) & 255; cy = (s >>> (n - 1)) & 1; end
            OP_LSL: begin res = (d << n) & 255; cy = ((d << (n - 1)) >> 7) & 1; end
            default: begin res = ((d >> n) | (d << (8 - n))) & 255; cy = (res >> 7) & 1; end
        endcase
    endfunction

    task automatic run(input logic [1:0] op, input int amt, input int d, input bit flood);
        int res, cy, n, cyc, busy_cnt;
        bit seen;
        model(op, amt, d, res, cy);
        n = amt > 8 ? 8 : amt;
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.amount = 4'(amt); bus.data_in = 8'(d);
        @(posedge clk);
        seen = 0; cyc = 0; busy_cnt = 0;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            bus.start   = flood;
            bus.op      = 2'($urandom);
            bus.amount  = 4'($urandom);
            bus.data_in = 8'($urandom);
            if (bus.busy) busy_cnt++;
            if (bus.done) seen = 1;
        end
        check("done_seen", 32'(seen), 1);
        check("latency", 32'(cyc), 32'(n + 1));
        check("busy_cycles", 32'(busy_cnt), 32'(n + 1));
        check("result", 32'(bus.result), 32'(res));
        check("carry", 32'(bus.carry), 32'(cy));
        check("zero", 32'(bus.zero), 32'(res == 0));
        bus.start = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'(bus.busy), 0);
        check("idle_done", 32'(bus.done), 0);
        check("hold_result", 32'(bus.result), 32'(res));
    endtask

    initial begin
        int r, c, dn;
        bus.start = 1'b0; bus.op = OP_LSR; bus.amount = '0; bus.data_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_result", 32'(bus.result), 0);
        check("rst_carry", 32'(bus.carry), 0);
        check("rst_zero", 32'(bus.zero), 1);
        model(OP_LSR, 3, 8'hB5, r, c);
        check("model_lsr", 32'(r), 32'h16);
        run(OP_LSR, 3, 8'hB5, 0);
        run(OP_ASR, 2, 8'h90, 0);
        run(OP_ROR, 1, 8'h01, 0);
        run(OP_LSL, 1, 8'h81, 0);
        run(2'($urandom), 0, 8'h5A, 0);
        run(OP_LSR, 15, 8'hFF, 0);
        run(OP_LSL, 4, 8'h01, 1);
        run(OP_ASR, 4, 8'h33, 0);
        run(OP_LSL, 8, 8'h81, 0);
        run(OP_ASR, 8, 8'h80, 0);
        run(OP_ROR, 8, 8'hA7, 0);
        run(OP_LSR, 8, 8'h80, 0);
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_LSR; bus.amount = 4'd5; bus.data_in = 8'hF0;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_result", 32'(bus.result), 0);
        check("abort_carry", 32'(bus.carry), 0);
        check("abort_zero", 32'(bus.zero), 1);
        dn = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done) dn++;
        end
        check("abort_no_done", 32'(dn), 0);
        for (int i = 0; i < 40; i++)
            run(2'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 255)), bit'($urandom));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
